// File: rtl/serial_subt_pkg.sv
// Shared types and bit-level helpers for the bit-serial subtractor.
package serial_subt_pkg;

    // Controller states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Difference bit of a single full-subtract step.
    function automatic logic sub_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Borrow-out of a single full-subtract step.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

endpackage

// File: rtl/full_subt.sv
// Combinational one-bit full-subtract cell: d = x - y - bin, bout = borrow.
module full_subt
    import serial_subt_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of one bit position.
    always_comb begin
        d    = sub_diff(x, y, bin);
        bout = sub_borrow(x, y, bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock,
// with a start/busy/done handshake.
// Optional build macro SERIAL_SUBT_OVF_EN enables the signed overflow flag;
// without it ovf is a constant 0 and no operand MSB capture is built.
module serial_subtractor
    import serial_subt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] dreg_r;
    logic             bor_r;
    logic [CW-1:0]    cnt_r;

    logic             d_s;
    logic             bout_s;
    logic [WIDTH-1:0] diff_next_s;
    logic             load_s;
    logic             fin_s;

    full_subt u_cell (
        .x    (a_r[0]),
        .y    (b_r[0]),
        .bin  (bor_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next diff-register value, load acceptance and final-bit detection.
    always_comb begin
        diff_next_s            = dreg_r >> 1;
        diff_next_s[WIDTH-1]   = d_s;
        load_s = start && ((state_r == IDLE) || (state_r == DONE));
        fin_s  = (state_r == SHIFT) && (cnt_r == CNT_LAST);
    end

    // Controller, datapath shift registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            dreg_r  <= '0;
            bor_r   <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (load_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        bor_r   <= 1'b0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    dreg_r <= diff_next_s;
                    bor_r  <= bout_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (fin_s) begin
                        diff    <= diff_next_s;
                        borrow  <= bout_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (load_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        bor_r   <= 1'b0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBT_OVF_EN
    logic a_msb_r;
    logic b_msb_r;

    // Capture operand sign bits on load; flag signed overflow on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf     <= 1'b0;
        end else if (load_s) begin
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end else if (fin_s) begin
            ovf     <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
        end else begin
            ovf     <= ovf;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: one WIDTH=8 and one WIDTH=1
// instance, scoreboard queues filled at stimulus time and drained on done.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       busy8, done8, borrow8, ovf8;
    logic [7:0] diff8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       busy1, done1, borrow1, ovf1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input int c);
        exp_t e;
        logic [8:0] full;
        logic [7:0] mask;
        int msb;
        mask = (w == 8) ? 8'hFF : 8'h01;
        msb  = w - 1;
        full = {1'b0, a & mask} - {1'b0, b & mask};
        e.diff   = full[7:0] & mask;
        e.borrow = ((a & mask) < (b & mask));
`ifdef SERIAL_SUBT_OVF_EN
        e.ovf = (a[msb] != b[msb]) && (e.diff[msb] != a[msb]);
`else
        e.ovf = 1'b0;
`endif
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard check for the 8-bit instance.
    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            chk("w8_done_expected", {31'd0, (q8.size() > 0)}, 32'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8_diff", {24'd0, diff8}, {24'd0, e.diff});
                chk("w8_borrow", {31'd0, borrow8}, {31'd0, e.borrow});
                chk("w8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
                chk("w8_latency", cyc, e.cyc);
                chk("w8_busy_at_done", {31'd0, busy8}, 32'd0);
            end
        end
    end

    // Scoreboard check for the 1-bit instance.
    always @(negedge clk) begin
        if (done1) begin
            exp_t e;
            chk("w1_done_expected", {31'd0, (q1.size() > 0)}, 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("w1_diff", {31'd0, diff1}, {31'd0, e.diff[0]});
                chk("w1_borrow", {31'd0, borrow1}, {31'd0, e.borrow});
                chk("w1_latency", cyc, e.cyc);
            end
        end
    end

    // One start pulse on the 8-bit instance; expected result queued if tracked.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit track);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        if (track) q8.push_back(model(8, a, b, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b;
        q1.push_back(model(1, {7'd0, a}, {7'd0, b}, cyc + 1 + 1));
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Wait for both scoreboards to drain, bounded.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, q8.size() + q1.size(), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_borrow", {31'd0, borrow8}, 32'd0);
        chk("rst_ovf", {31'd0, ovf8}, 32'd0);
        chk("rst_w1_diff", {31'd0, diff1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        go8(8'd5, 8'd3, 1'b1);
        chk("busy_during_shift", {31'd0, busy8}, 32'd1);
        drain("drain_5_3");
        go8(8'd3, 8'd5, 1'b1);
        drain("drain_3_5");
        go8(8'h80, 8'h01, 1'b1);
        drain("drain_80_01");
        go8(8'h7F, 8'hFF, 1'b1);
        drain("drain_7f_ff");

        go1(1'b0, 1'b0); drain("drain_w1_00");
        go1(1'b0, 1'b1); drain("drain_w1_01");
        go1(1'b1, 1'b0); drain("drain_w1_10");
        go1(1'b1, 1'b1); drain("drain_w1_11");

        // Start during SHIFT must be ignored.
        go8(8'h55, 8'h22, 1'b1);
        @(negedge clk);
        go8(8'hAA, 8'h01, 1'b0);
        drain("drain_ignored_start");
        repeat (12) @(negedge clk);

        // Reset mid-SHIFT aborts the operation without a done pulse.
        go8(8'h44, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'd0);
        chk("abort_borrow", {31'd0, borrow8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go8(8'h20, 8'h08, 1'b1);
        drain("drain_after_abort");

        // Start held high: back-to-back results every WIDTH+1 cycles.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        for (int i = 0; i < 3; i++) q8.push_back(model(8, 8'h10, 8'h01, cyc + 1 + 8 + 9 * i));
        drain("drain_held_start");
        start8 = 1'b0;
        repeat (14) @(negedge clk);
        chk("final_q8_empty", q8.size(), 32'd0);
        chk("final_idle", {31'd0, busy8}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
